branch_pc_unit: RTL
===================

Name: branch_pc_unit

Overview:
Owns the program counter and the condition state that branch decisions consume. Latches the ALU carry flag, derives the zero and sign conditions from the rs operand, and evaluates all eight KGP-RISC branch opcodes. Computes the next PC, drives the link write for bl, and issues a squash window after every taken branch. Sits between the decode stage and instruction fetch.

Parameters:
PC_W, 32, program counter and rs data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 1, squash cycles after a taken branch (1..3)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Stall  in  1  freeze PC, flush counter and decisions
InstrValid  in  1  OpCode, RsData and Offset describe a live instruction
OpCode  in  6  instruction opcode
RsData  in  PC_W  rs register value
Offset  in  26  branch word offset (signed)
CarryIn  in  1  carry from the ALU
CarryWrEn  in  1  ALU instruction updates carry
PC  out  PC_W  current fetch address
BranchTaken  out  1  registered 1-cycle pulse: branch resolved taken
Flush  out  1  squash the instruction in decode
LinkWrEn  out  1  registered 1-cycle pulse: write LinkData to ra
LinkData  out  PC_W  return address (PC+4 of bl)
FlagCarry  out  1  architectural carry flag

Behaviour:
- Reset (async, rst_n=0) sets PC=RESET_PC, FlagCarry=0, BranchTaken=0, Flush=0, LinkWrEn=0, LinkData=0, state=RUN, flush count=0. Reset mid-flush abandons the flush.
- Carry register: on a rising edge with CarryWrEn=1, FlagCarry<=CarryIn. This update is independent of Stall and Flush.
- Effective carry for a decision is CarryIn when CarryWrEn=1 in the same cycle, otherwise FlagCarry (forwarding).
- Zero = (RsData==0). Sign = RsData[PC_W-1].
- Branch conditions:
  - b 101000: always taken. bl 101011: always taken.
  - br 100000: always taken, target = RsData.
  - bltz 110000: taken when Sign=1.
  - bz 110001: taken when Zero=1.
  - bnz 110010: taken when Zero=0.
  - bcy 101001: taken when carry=1.
  - bncy 101010: taken when carry=0.
  - Any other opcode is not a branch.
- Relative target = PC + 4 + (sext(Offset) << 2). For 1100xx opcodes only Offset[15:0] is used, sign-extended. For 1010xx opcodes all 26 bits are used. Arithmetic is modulo 2^PC_W, so wrap-around is silent.
- Decision fires only when InstrValid=1, Stall=0 and state=RUN.
- State RUN:
  - Decision taken: PC <= target next edge, BranchTaken=1 for one cycle, go to FLUSH with count=FLUSH_CYCLES.
  - bl additionally sets LinkWrEn=1 and LinkData=PC+4, both registered on the same edge.
  - Otherwise: PC <= PC+4, unless Stall=1, in which case PC holds.
- State FLUSH:
  - Flush=1. Branch opcodes are ignored.
  - PC <= PC+4 per unstalled cycle. The counter decrements per unstalled cycle.
  - Return to RUN when the counter reaches 1 and is decremented.
  - Stall holds the PC, the counter and Flush=1.
- Latency: the branch decision is combinational from inputs in cycle t. PC, BranchTaken and LinkWrEn update at edge t+1. Flush is high from t+1 for FLUSH_CYCLES unstalled cycles.
- A stalled cycle never produces BranchTaken or LinkWrEn.
- BranchTaken and LinkWrEn are registered and never asserted back to back without an intervening RUN decision.

Decomposition:
- Package kgp_isa_pkg holds the opcode localparams: OP_B, OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BL, OP_BCY, OP_BNCY. It also holds the 2-state enum {RUN, FLUSH}.
- Sub-module branch_cond_eval: purely combinational. Inputs are OpCode, Zero, Sign and Carry. Outputs are is_branch and take.
- The top module holds the flag register, PC, FSM, target adder and link logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Expect PC=0, Flush=0, FlagCarry=0. PC steps 0, 4, 8 on the next three edges.
- b at PC=0x10 with Offset=26'h3FFFFFE (-2): next PC = 0x10+4-8 = 0x0C, BranchTaken pulse, Flush=1 for 1 cycle, then PC=0x10.
- bz/bnz/bltz:
  - RsData=0: bz taken, bnz not taken.
  - RsData=32'h8000_0000: bltz taken, bz not taken.
  - Offset=16'h0004 at PC=0x20: target 0x34.
- Carry forwarding:
  - CarryWrEn=1, CarryIn=1 in the same cycle as bcy: taken.
  - Next cycle, bncy with CarryWrEn=0 uses FlagCarry=1: not taken.
- bl at PC=0x40, Offset=8: PC becomes 0x64, LinkWrEn=1, LinkData=0x44. br with RsData=0x44 returns PC to 0x44.
- Stall during FLUSH holds PC and Flush for 2 cycles. A bz taken under Stall=1 produces no BranchTaken. Asserting rst_n=0 mid-flush gives PC=RESET_PC and Flush=0 immediately.

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// KGP-RISC branch opcodes and the PC unit state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package kgp_isa_pkg;

  localparam logic [5:0] OP_BR   = 6'b100000;
  localparam logic [5:0] OP_B    = 6'b101000;
  localparam logic [5:0] OP_BCY  = 6'b101001;
  localparam logic [5:0] OP_BNCY = 6'b101010;
  localparam logic [5:0] OP_BL   = 6'b101011;
  localparam logic [5:0] OP_BLTZ = 6'b110000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;

  // RUN accepts branch decisions; FLUSH squashes wrong-path fetches.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: classifies OpCode and decides taken/not-taken.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies with valid/stall.
// Ports: OpCode (6b), Zero, Sign, Carry in; is_branch, take out.
module branch_cond_eval
  import kgp_isa_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       Sign,
  input  logic       Carry,
  output logic       is_branch,
  output logic       take
);

  always_comb begin
    is_branch = 1'b0;
    take      = 1'b0;
    case (OpCode)
      OP_B, OP_BL, OP_BR: begin
        is_branch = 1'b1;
        take      = 1'b1;
      end
      OP_BLTZ: begin
        is_branch = 1'b1;
        take      = Sign;
      end
      OP_BZ: begin
        is_branch = 1'b1;
        take      = Zero;
      end
      OP_BNZ: begin
        is_branch = 1'b1;
        take      = ~Zero;
      end
      OP_BCY: begin
        is_branch = 1'b1;
        take      = Carry;
      end
      OP_BNCY: begin
        is_branch = 1'b1;
        take      = ~Carry;
      end
      default: begin
        is_branch = 1'b0;
        take      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter, carry flag, branch resolution, link write and squash window.
// Latency: decision combinational in cycle t; PC/BranchTaken/LinkWrEn update at edge t+1.
// Backpressure: Stall freezes PC, flush counter and decisions; carry still updates.
// Ports: clk, rst_n; Stall, InstrValid, OpCode, RsData, Offset, CarryIn, CarryWrEn in;
//        PC, BranchTaken, Flush, LinkWrEn, LinkData, FlagCarry out.
module branch_pc_unit
  import kgp_isa_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            InstrValid,
  input  logic [5:0]      OpCode,
  input  logic [PC_W-1:0] RsData,
  input  logic [25:0]     Offset,
  input  logic            CarryIn,
  input  logic            CarryWrEn,
  output logic [PC_W-1:0] PC,
  output logic            BranchTaken,
  output logic            Flush,
  output logic            LinkWrEn,
  output logic [PC_W-1:0] LinkData,
  output logic            FlagCarry
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  pc_state_e       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_carry_q, flag_carry_d;
  logic            branch_taken_q, branch_taken_d;
  logic            link_wr_en_q, link_wr_en_d;
  logic [PC_W-1:0] link_data_q, link_data_d;

  logic            zero, sign, carry_eff;
  logic            is_branch, take, decide;
  logic [PC_W-1:0] pc_plus4, off_ext, target;

  assign zero      = (RsData == '0);
  assign sign      = RsData[PC_W-1];
  // An ALU op writing carry in the same cycle is forwarded into the decision.
  assign carry_eff = CarryWrEn ? CarryIn : flag_carry_q;

  branch_cond_eval u_cond (
    .OpCode    (OpCode),
    .Zero      (zero),
    .Sign      (sign),
    .Carry     (carry_eff),
    .is_branch (is_branch),
    .take      (take)
  );

  assign decide   = InstrValid && !Stall && (state_q == RUN) && is_branch && take;
  assign pc_plus4 = pc_q + PC_W'(4);

  // Conditional (1100xx) forms carry a 16-bit offset; jump (1010xx) forms use all 26 bits.
  always_comb begin
    if (OpCode[5:2] == 4'b1100) begin
      off_ext = {{(PC_W-16){Offset[15]}}, Offset[15:0]};
    end else begin
      off_ext = {{(PC_W-26){Offset[25]}}, Offset};
    end
  end

  always_comb begin
    if (OpCode == OP_BR) begin
      target = RsData;
    end else begin
      target = pc_plus4 + (off_ext << 2);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    branch_taken_d = 1'b0;
    link_wr_en_d   = 1'b0;
    link_data_d    = link_data_q;
    flag_carry_d   = CarryWrEn ? CarryIn : flag_carry_q;

    case (state_q)
      RUN: begin
        if (decide) begin
          pc_d           = target;
          branch_taken_d = 1'b1;
          state_d        = FLUSH;
          cnt_d          = FLUSH_INIT;
          if (OpCode == OP_BL) begin
            link_wr_en_d = 1'b1;
            link_data_d  = pc_plus4;
          end
        end else if (!Stall) begin
          pc_d = pc_plus4;
        end
      end
      FLUSH: begin
        // Fetch keeps running down the new path; only the count of squashed slots matters.
        if (!Stall) begin
          pc_d  = pc_plus4;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      pc_q           <= RESET_PC;
      flag_carry_q   <= 1'b0;
      branch_taken_q <= 1'b0;
      link_wr_en_q   <= 1'b0;
      link_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      flag_carry_q   <= flag_carry_d;
      branch_taken_q <= branch_taken_d;
      link_wr_en_q   <= link_wr_en_d;
      link_data_q    <= link_data_d;
    end
  end

  assign PC          = pc_q;
  assign BranchTaken = branch_taken_q;
  assign Flush       = (state_q == FLUSH);
  assign LinkWrEn    = link_wr_en_q;
  assign LinkData    = link_data_q;
  assign FlagCarry   = flag_carry_q;

endmodule
